// File: rtl/mutex_arbiter_pkg.sv
// mutex_arbiter_pkg: shared state encoding and width helpers for the mutex arbiter.
package mutex_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return r;
    endfunction

    function automatic int idw_f(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/mutex_arbiter_rr_pick.sv
// rr_pick: first set bit of mask at or after ptr, wrapping from N-1 back to 0.
module rr_pick
    import mutex_arbiter_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = idw_f(N)
) (
    input  logic [N-1:0]   mask_i,
    input  logic [IDW-1:0] ptr_i,
    output logic           found_o,
    output logic [IDW-1:0] idx_o
);

    // Walk from the farthest candidate down so the nearest one is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (mask_i[(int'(ptr_i) + k) % N]) begin
                found_o = 1'b1;
                idx_o   = IDW'((int'(ptr_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/mutex_arbiter.sv
// mutex_arbiter: round-robin lock manager with four-phase handshake, dead cycle
// between owners and an optional hold watchdog that revokes and blocks the offender.
module mutex_arbiter
    import mutex_arbiter_pkg::*;
#(
    parameter int N = 4,
    parameter int MAX_HOLD = 0,
    localparam int IDW = idw_f(N)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] owner,
    output logic           busy,
    output logic           timeout_err,
    output logic [IDW-1:0] timeout_id
);

    localparam int CW = idw_f(MAX_HOLD + 1);
    localparam int LIM = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
    localparam logic [IDW-1:0] LAST = IDW'(N - 1);

    state_e         state_q;
    logic [N-1:0]   grant_q, blocked_q;
    logic [IDW-1:0] owner_q, ptr_q, tid_q, win, nxt_ptr;
    logic [CW-1:0]  cnt_q;
    logic           busy_q, terr_q, found, own_req, revoke;

    rr_pick #(.N(N)) u_pick (
        .mask_i  (req & ~blocked_q),
        .ptr_i   (ptr_q),
        .found_o (found),
        .idx_o   (win)
    );

    assign own_req = req[owner_q];
    // Release beats expiry: a revoke needs the owner to still be requesting.
    assign revoke  = (MAX_HOLD > 0) && (state_q == GRANT) && own_req && (cnt_q == CW'(LIM));
    assign nxt_ptr = (owner_q == LAST) ? '0 : owner_q + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            blocked_q <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            tid_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            terr_q    <= 1'b0;
        end else begin
            terr_q    <= 1'b0;
            blocked_q <= (blocked_q | (revoke ? grant_q : '0)) & req;
            case (state_q)
                IDLE: if (found) begin
                    grant_q <= N'(1) << win;
                    owner_q <= win;
                    busy_q  <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= GRANT;
                end
                GRANT: if (!own_req || revoke) begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= nxt_ptr;
                    terr_q  <= revoke;
                    state_q <= RELEASE;
                    if (revoke) tid_q <= owner_q;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign owner       = owner_q;
    assign busy        = busy_q;
    assign timeout_err = terr_q;
    assign timeout_id  = tid_q;

endmodule

// File: tb/tb_mutex_arbiter.sv
// tb_mutex_arbiter: directed and random stimulus against a behavioural lock model, N=4, MAX_HOLD=8.
module tb_mutex_arbiter;

    localparam int N = 4;
    localparam int MAXH = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] grant;
    logic [1:0] owner, tid;
    logic       busy, terr;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: who holds the lock (-1 = nobody), how long, dead-cycle flag, fairness pointer.
    int         m_own = -1;
    int         m_held = 0;
    bit         m_dead = 0;
    int         m_ptr = 0;
    bit [3:0]   m_blk = '0;
    bit         m_terr = 0;
    int         m_tid = 0;

    mutex_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (req),
        .grant       (grant),
        .owner       (owner),
        .busy        (busy),
        .timeout_err (terr),
        .timeout_id  (tid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic model_step(input logic [3:0] r, input logic rn);
        bit [3:0] nb;
        if (!rn) begin
            m_own = -1; m_held = 0; m_dead = 0; m_ptr = 0; m_blk = '0; m_terr = 0; m_tid = 0;
            return;
        end
        m_terr = 0;
        nb = m_blk;
        if (m_own >= 0) begin
            if (!r[m_own]) begin
                m_ptr = (m_own + 1) % N; m_own = -1; m_dead = 1;
            end else if (m_held == MAXH) begin
                m_terr = 1; m_tid = m_own; nb[m_own] = 1'b1;
                m_ptr = (m_own + 1) % N; m_own = -1; m_dead = 1;
            end else begin
                m_held++;
            end
        end else if (m_dead) begin
            m_dead = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (m_ptr + k) % N;
                if (m_own < 0 && r[j] && !m_blk[j]) begin
                    m_own = j; m_held = 1;
                end
            end
        end
        m_blk = nb & r;
    endtask

    task automatic compare();
        chk("grant", grant, (m_own >= 0) ? (32'd1 << m_own) : 32'd0);
        chk("busy", busy, (m_own >= 0) ? 32'd1 : 32'd0);
        if (m_own >= 0) chk("owner", owner, m_own);
        chk("timeout_err", terr, m_terr);
        chk("timeout_id", tid, m_tid);
    endtask

    task automatic cycle(input logic [3:0] r, input logic rn = 1'b1);
        req = r;
        reset_n = rn;
        @(posedge clk);
        model_step(r, rn);
        cyc++;
        @(negedge clk);
        compare();
    endtask

    initial begin
        int n;
        bit seen;
        logic [3:0] rr;
        @(negedge clk);
        cycle(4'b0000, 1'b0);
        cycle(4'b0000, 1'b0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_terr", terr, 0);
        chk("rst_tid", tid, 0);
        cycle(4'b0001);
        chk("first_grant", grant, 4'b0001);
        chk("first_owner", owner, 0);
        repeat (3) cycle(4'b0001);
        cycle(4'b0000);
        chk("release_low", grant, 0);
        cycle(4'b0010);
        chk("dead_cycle", grant, 0);
        cycle(4'b0010);
        chk("second_grant", grant, 4'b0010);
        cycle(4'b0000);
        cycle(4'b0000);
        // Watchdog: 2 holds forever while 1 waits.
        cycle(4'b0110);
        chk("wd_grant", grant, 4'b0100);
        n = 1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cycle(4'b0110);
            if (grant == 4'b0100) n++;
            if (terr) seen = 1;
        end
        chk("wd_fired", seen, 1);
        chk("wd_hold_len", n, MAXH);
        chk("wd_id", tid, 2);
        cycle(4'b0110);
        chk("wd_dead", grant, 0);
        cycle(4'b0110);
        chk("wd_next", grant, 4'b0010);
        cycle(4'b0100);
        repeat (3) cycle(4'b0100);
        chk("blocked", grant, 0);
        cycle(4'b0000);
        cycle(4'b0100);
        chk("unblocked", grant, 4'b0100);
        cycle(4'b0000);
        cycle(4'b0000);
        // Owner releases exactly as the hold limit is reached.
        cycle(4'b1000);
        chk("edge_grant", grant, 4'b1000);
        repeat (7) cycle(4'b1000);
        cycle(4'b0000);
        chk("edge_no_err", terr, 0);
        chk("edge_released", grant, 0);
        cycle(4'b1000);
        cycle(4'b1000);
        chk("edge_not_blocked", grant, 4'b1000);
        cycle(4'b0000);
        cycle(4'b0000);
        // Round-robin wrap.
        cycle(4'b0010);
        chk("wrap_owner1", grant, 4'b0010);
        cycle(4'b0011);
        cycle(4'b0001);
        cycle(4'b0011);
        cycle(4'b0011);
        chk("wrap_to_0", grant, 4'b0001);
        cycle(4'b0000);
        cycle(4'b0000);
        // Reset while granted.
        cycle(4'b1000);
        chk("pre_rst_grant", grant, 4'b1000);
        cycle(4'b1000, 1'b0);
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_terr", terr, 0);
        cycle(4'b1000);
        chk("post_rst_grant", grant, 4'b1000);
        // Random persistent requests with rare resets.
        rr = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 9) == 0) rr[b] = ~rr[b];
            cycle(rr, $urandom_range(0, 299) != 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
